// File: rtl/iw_pkg.sv
// Shared types and constants for the instruction-word assembler.
//   instruction_word_t : packed {a, b, opcode, address}, a in the MSBs.
//   asm_state_t        : beat-assembly state (ST_A -> ST_B -> ST_OP).
//   OPCODE_MAX         : highest opcode forwarded when IW_OPCODE_CHECK_EN is defined.
//   IW_W               : width of instruction_word_t (96).
package iw_pkg;

  typedef struct packed {
    int        a;
    int        b;
    byte       opcode;
    bit [23:0] address;
  } instruction_word_t;

  typedef enum logic [1:0] {
    ST_A,
    ST_B,
    ST_OP
  } asm_state_t;

  localparam logic [7:0]  OPCODE_MAX = 8'h3F;
  localparam int unsigned IW_W       = $bits(instruction_word_t);

endpackage

// File: rtl/iw_assembler_if.sv
// Handshake bundle between the fetch bus, the assembler and the ALU IW input.
//   in_valid/in_ready/in_data/in_first : 32-bit beat stream into the assembler.
//   iw_valid/iw_ready/iw               : assembled instruction words out to the ALU.
// Modports:
//   master : environment side (drives beats, consumes words).
//   slave  : assembler side.
interface iw_assembler_if;
  import iw_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_data;
  logic              in_first;
  logic              iw_valid;
  logic              iw_ready;
  instruction_word_t iw;

  modport master (
    output in_valid, in_data, in_first, iw_ready,
    input  in_ready, iw_valid, iw
  );

  modport slave (
    input  in_valid, in_data, in_first, iw_ready,
    output in_ready, iw_valid, iw
  );

endinterface

// File: rtl/iw_fifo.sv
// Synchronous FIFO of instruction_word_t entries.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset.
//   i_push/i_data: write an entry (ignored when full).
//   i_pop        : drop the head entry (ignored when empty).
//   o_data       : head entry; reads zero while the FIFO is empty.
//   o_count      : number of entries held (0..DEPTH).
//   o_full/o_empty: occupancy flags.
// Parameter DEPTH must be a power of two >= 2; pointers wrap naturally.
module iw_fifo
  import iw_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_push,
  input  instruction_word_t        i_data,
  input  logic                     i_pop,
  output instruction_word_t        o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  instruction_word_t r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CW-1:0]     r_count;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/iw_assembler.sv
// Assembles 3-beat groups from the fetch bus into instruction_word_t and
// queues them for the ALU.
//   beat0 -> a, beat1 -> b, beat2 -> {opcode[31:24], address[23:0]}
// Ports:
//   clock, reset   : rising-edge clock, synchronous active-high reset.
//   bus (slave)    : beat input (in_*) and word output (iw_*) handshakes.
//   fifo_count     : words currently queued.
//   resync_errs    : saturating count of partial instructions / stray beats discarded.
//   opcode_drops   : saturating count of words rejected by the opcode check.
// Build option IW_OPCODE_CHECK_EN: when defined, words whose opcode exceeds
// OPCODE_MAX are dropped instead of queued; otherwise opcode_drops reads 0.
module iw_assembler
  import iw_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  iw_assembler_if.slave          bus,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [CNT_W-1:0]       resync_errs,
  output logic [CNT_W-1:0]       opcode_drops
);

  asm_state_t        r_state;
  asm_state_t        w_state_nxt;
  logic [31:0]       r_a;
  logic [31:0]       r_b;
  logic [CNT_W-1:0]  r_resync_errs;

  logic              w_in_ready;
  logic              w_accept;
  logic              w_cap_a;
  logic              w_cap_b;
  logic              w_push;
  logic              w_err;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  instruction_word_t w_word;
  instruction_word_t w_head;

`ifdef IW_OPCODE_CHECK_EN
  logic              w_drop;
  logic              w_opcode_ok;
  logic [CNT_W-1:0]  r_opcode_drops;

  assign w_opcode_ok = (bus.in_data[31:24] <= OPCODE_MAX);
`endif

  // The completed word is formed from the registered a/b and the live beat2.
  always_comb begin
    w_word         = '0;
    w_word.a       = r_a;
    w_word.b       = r_b;
    w_word.opcode  = bus.in_data[31:24];
    w_word.address = bus.in_data[23:0];
  end

  // Next-state and control. in_ready depends only on state and FIFO
  // occupancy, never on iw_ready.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b1;
    w_accept    = 1'b0;
    w_cap_a     = 1'b0;
    w_cap_b     = 1'b0;
    w_push      = 1'b0;
    w_err       = 1'b0;
`ifdef IW_OPCODE_CHECK_EN
    w_drop      = 1'b0;
`endif

    if (r_state == ST_OP) w_in_ready = !w_full;
    w_accept = bus.in_valid && w_in_ready;

    if (w_accept) begin
      case (r_state)
        ST_A: begin
          if (bus.in_first) begin
            w_cap_a     = 1'b1;
            w_state_nxt = ST_B;
          end else begin
            w_err = 1'b1;
          end
        end
        ST_B: begin
          if (bus.in_first) begin
            w_err   = 1'b1;
            w_cap_a = 1'b1;
          end else begin
            w_cap_b     = 1'b1;
            w_state_nxt = ST_OP;
          end
        end
        ST_OP: begin
          if (bus.in_first) begin
            w_err       = 1'b1;
            w_cap_a     = 1'b1;
            w_state_nxt = ST_B;
          end else begin
            w_state_nxt = ST_A;
`ifdef IW_OPCODE_CHECK_EN
            if (w_opcode_ok) w_push = 1'b1;
            else             w_drop = 1'b1;
`else
            w_push = 1'b1;
`endif
          end
        end
        default: w_state_nxt = ST_A;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= ST_A;
      r_a           <= '0;
      r_b           <= '0;
      r_resync_errs <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cap_a) r_a <= bus.in_data;
      if (w_cap_b) r_b <= bus.in_data;
      if (w_err && (r_resync_errs != '1))
        r_resync_errs <= r_resync_errs + CNT_W'(1);
    end
  end

`ifdef IW_OPCODE_CHECK_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      r_opcode_drops <= '0;
    end else if (w_drop && (r_opcode_drops != '1)) begin
      r_opcode_drops <= r_opcode_drops + CNT_W'(1);
    end
  end

  assign opcode_drops = r_opcode_drops;
`else
  assign opcode_drops = '0;
`endif

  iw_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_word),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (fifo_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_pop        = !w_empty && bus.iw_ready;
  assign bus.in_ready = w_in_ready;
  assign bus.iw_valid = !w_empty;
  assign bus.iw       = w_head;
  assign resync_errs  = r_resync_errs;

endmodule

// File: tb/tb_iw_assembler.sv
// Self-checking bench for iw_assembler. Expected words are pushed to a
// scoreboard queue when beat2 is accepted and popped by an output monitor.
module tb_iw_assembler;
  import iw_pkg::*;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned CMAX  = (1 << CNT_W) - 1;

  logic                   clock = 1'b0;
  logic                   reset;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [CNT_W-1:0]       resync_errs;
  logic [CNT_W-1:0]       opcode_drops;

  iw_assembler_if bus ();

  iw_assembler #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus),
    .fifo_count   (fifo_count),
    .resync_errs  (resync_errs),
    .opcode_drops (opcode_drops)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  asm_state_t        m_state;
  logic [31:0]       m_a;
  logic [31:0]       m_b;
  int unsigned       m_errs;
  int unsigned       m_drops;
  instruction_word_t sb[$];

  function automatic void model_reset();
    m_state = ST_A;
    m_a     = '0;
    m_b     = '0;
    m_errs  = 0;
    m_drops = 0;
    sb.delete();
  endfunction

  function automatic void model_accept(input logic [31:0] d, input logic f);
    instruction_word_t w;
    if (f) begin
      if (m_state != ST_A && m_errs < CMAX) m_errs++;
      m_a     = d;
      m_state = ST_B;
    end else if (m_state == ST_A) begin
      if (m_errs < CMAX) m_errs++;
    end else if (m_state == ST_B) begin
      m_b     = d;
      m_state = ST_OP;
    end else begin
      w         = '0;
      w.a       = m_a;
      w.b       = m_b;
      w.opcode  = d[31:24];
      w.address = d[23:0];
      m_state   = ST_A;
`ifdef IW_OPCODE_CHECK_EN
      if (d[31:24] > 8'h3F) begin
        if (m_drops < CMAX) m_drops++;
      end else begin
        sb.push_back(w);
      end
`else
      sb.push_back(w);
`endif
    end
  endfunction

  // Output monitor: order/content of popped words and head stability under stall.
  instruction_word_t held;
  logic              held_v = 1'b0;
  always @(negedge clock) begin
    if (reset) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        n_tests++;
        if (bus.iw_valid !== 1'b1 || bus.iw !== held) begin
          n_fail++;
          $display("FAIL iw_stable: got valid=%b iw=%h want valid=1 iw=%h", bus.iw_valid, bus.iw, held);
        end
      end
      if (bus.iw_valid === 1'b1 && bus.iw_ready === 1'b1) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL iw_unexpected: got iw=%h want no word", bus.iw);
        end else begin
          instruction_word_t exp;
          exp = sb.pop_front();
          if (bus.iw !== exp) begin
            n_fail++;
            $display("FAIL iw_word: got %h want %h", bus.iw, exp);
          end
        end
      end
      held_v = bus.iw_valid && !bus.iw_ready;
      held   = bus.iw;
    end
  end

  // Drive one beat, wait (bounded) for acceptance, update the model on the accept edge.
  task automatic send_beat(input logic [31:0] d, input logic f);
    int unsigned n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_first = f;
    @(negedge clock);
    while (bus.in_ready !== 1'b1 && n < 100) begin
      n++;
      @(negedge clock);
    end
    if (bus.in_ready !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL beat_timeout: got in_ready=%b want 1 within 100 cycles", bus.in_ready);
    end else begin
      @(posedge clock);
      model_accept(d, f);
    end
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic send_instr(input logic [31:0] a, input logic [31:0] b, input logic [31:0] op);
    send_beat(a, 1'b1);
    send_beat(b, 1'b0);
    send_beat(op, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    model_reset();
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && fifo_count != 0; i++) begin
      @(posedge clock);
      #1;
    end
    @(posedge clock);
    #1;
    n_tests++;
    if (fifo_count !== '0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: got fifo_count=%0d pending=%0d want 0 and 0", name, fifo_count, sb.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    n_tests++;
    if (bus.iw_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.iw !== '0 ||
        fifo_count !== '0 || resync_errs !== '0 || opcode_drops !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got valid=%b rdy=%b iw=%h cnt=%0d errs=%0d drops=%0d want 0 1 0 0 0 0",
               bus.iw_valid, bus.in_ready, bus.iw, fifo_count, resync_errs, opcode_drops);
    end
    @(posedge clock);
    #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    do_reset();
    bus.iw_ready = 1'b1;
    send_beat(32'h11111111, 1'b1);
    send_beat(32'h22222222, 1'b0);
    n_tests++;
    if (bus.iw_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_early_valid: got %b want 0", bus.iw_valid);
    end
    send_beat(32'h05ABCDEF, 1'b0);
    n_tests++;
    if (bus.iw_valid !== 1'b1 || bus.iw.a !== 32'h11111111 || bus.iw.b !== 32'h22222222 ||
        bus.iw.opcode !== 8'h05 || bus.iw.address !== 24'hABCDEF) begin
      n_fail++;
      $display("FAIL basic_word: got valid=%b iw=%h want 1 11111111_22222222_05ABCDEF", bus.iw_valid, bus.iw);
    end
    @(posedge clock);
    #1;
    n_tests++;
    if (bus.iw_valid !== 1'b0 || fifo_count !== '0) begin
      n_fail++;
      $display("FAIL basic_pop: got valid=%b cnt=%0d want 0 0", bus.iw_valid, fifo_count);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.iw_ready = 1'b0;
    send_instr(32'hA0000001, 32'hB0000001, 32'h01000001);
    send_instr(32'hA0000002, 32'hB0000002, 32'h02000002);
    n_tests++;
    if (fifo_count !== 2) begin
      n_fail++;
      $display("FAIL bp_full_count: got %0d want 2", fifo_count);
    end
    send_beat(32'hA0000003, 1'b1);
    send_beat(32'hB0000003, 1'b0);
    n_tests++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_in_ready: got %b want 0", bus.in_ready);
    end
    fork
      send_beat(32'h03000003, 1'b0);
      begin
        repeat (3) @(posedge clock);
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b0 || fifo_count !== 2) begin
          n_fail++;
          $display("FAIL bp_stall: got rdy=%b cnt=%0d want 0 2", bus.in_ready, fifo_count);
        end
        bus.iw_ready = 1'b1;
      end
    join
    drain("bp");
  endtask

  task automatic test_resync();
    do_reset();
    bus.iw_ready = 1'b1;
    send_beat(32'h00000001, 1'b1);
    send_beat(32'h00000002, 1'b0);
    send_beat(32'hAAAA0000, 1'b1);
    send_beat(32'hBBBB0000, 1'b0);
    send_beat(32'h07123456, 1'b0);
    n_tests++;
    if (bus.iw_valid !== 1'b1 || bus.iw.a !== 32'hAAAA0000 || resync_errs !== 8'd1) begin
      n_fail++;
      $display("FAIL resync_word: got valid=%b a=%h errs=%0d want 1 aaaa0000 1", bus.iw_valid, bus.iw.a, resync_errs);
    end
    drain("resync");
  endtask

  task automatic test_stray();
    do_reset();
    bus.iw_ready = 1'b1;
    send_beat(32'h12345678, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    n_tests++;
    if (resync_errs !== 8'd1 || bus.iw_valid !== 1'b0 || fifo_count !== '0) begin
      n_fail++;
      $display("FAIL stray: got errs=%0d valid=%b cnt=%0d want 1 0 0", resync_errs, bus.iw_valid, fifo_count);
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    bus.iw_ready = 1'b0;
    send_instr(32'hC0000001, 32'hD0000001, 32'h09000001);
    send_beat(32'hC0000002, 1'b1);
    send_beat(32'hD0000002, 1'b0);
    n_tests++;
    if (fifo_count !== 1) begin
      n_fail++;
      $display("FAIL midop_queued: got %0d want 1", fifo_count);
    end
    reset = 1'b1;
    model_reset();
    @(posedge clock);
    #1 reset = 1'b0;
    n_tests++;
    if (bus.iw_valid !== 1'b0 || fifo_count !== '0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_flush: got valid=%b cnt=%0d rdy=%b want 0 0 1", bus.iw_valid, fifo_count, bus.in_ready);
    end
    bus.iw_ready = 1'b1;
    send_instr(32'hE0000003, 32'hF0000003, 32'h0A000003);
    drain("midop");
    n_tests++;
    if (resync_errs !== 8'(m_errs)) begin
      n_fail++;
      $display("FAIL midop_errs: got %0d want %0d", resync_errs, m_errs);
    end
  endtask

  task automatic test_opcode();
    do_reset();
    bus.iw_ready = 1'b1;
    send_instr(32'h00000040, 32'h00000041, 32'h40000001);
    n_tests++;
    if (bus.iw_valid !== (sb.size() != 0) || opcode_drops !== 8'(m_drops)) begin
      n_fail++;
      $display("FAIL op_40: got valid=%b drops=%0d want %b %0d", bus.iw_valid, opcode_drops, (sb.size() != 0), m_drops);
    end
    @(posedge clock);
    #1;
    send_instr(32'h0000003F, 32'h00000040, 32'h3F000002);
    n_tests++;
    if (bus.iw_valid !== 1'b1 || bus.iw.opcode !== 8'h3F) begin
      n_fail++;
      $display("FAIL op_3f: got valid=%b opcode=%h want 1 3f", bus.iw_valid, bus.iw.opcode);
    end
    drain("opcode");
`ifdef IW_OPCODE_CHECK_EN
    n_tests++;
    if (opcode_drops !== 8'd1) begin
      n_fail++;
      $display("FAIL op_drops: got %0d want 1", opcode_drops);
    end
`else
    n_tests++;
    if (opcode_drops !== 8'd0) begin
      n_fail++;
      $display("FAIL op_drops: got %0d want 0", opcode_drops);
    end
`endif
  endtask

  task automatic test_saturation();
    do_reset();
    bus.iw_ready = 1'b1;
    for (int i = 0; i < 260; i++) begin
      send_beat(32'(i), 1'b0);
      if (i == 254) begin
        n_tests++;
        if (resync_errs !== 8'hFF) begin
          n_fail++;
          $display("FAIL sat_255: got %h want ff", resync_errs);
        end
      end
    end
    n_tests++;
    if (resync_errs !== 8'hFF || resync_errs !== 8'(m_errs)) begin
      n_fail++;
      $display("FAIL sat_260: got %h want ff (model %0d)", resync_errs, m_errs);
    end
  endtask

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_first = 1'b0;
    bus.iw_ready = 1'b0;
    model_reset();

    test_reset();
    test_basic();
    test_backpressure();
    test_resync();
    test_stray();
    test_reset_midop();
    test_opcode();
    test_saturation();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/iw_assembler.md
Name: iw_assembler

Overview:
- Upstream neighbour of the ALU.
- Accepts a 32-bit beat stream from the fetch bus and assembles each 3-beat group into one packed instruction_word_t {a, b, opcode, address}.
- Buffers completed words in a small FIFO.
- Presents them to the ALU's IW input over a valid/ready handshake.

Parameters:
- DEPTH, 2, number of instruction_word_t entries in the output FIFO; power of two, ≥2.
- CNT_W, 8, width of the saturating error/drop counters.

Ports:
- clock  input  1  single rising-edge clock for all state.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  beat present on in_data.
- in_ready  output  1  block accepts the beat this cycle.
- in_data  input  32  beat payload.
- in_first  input  1  qualifies the beat as the first beat of an instruction (beat 0).
- iw_valid  output  1  iw holds a complete instruction word.
- iw_ready  input  1  ALU consumes iw this cycle.
- iw  output  96  instruction_word_t: a=[95:64], b=[63:32], opcode=[31:24], address=[23:0].
- fifo_count  output  $clog2(DEPTH)+1  entries currently held.
- resync_errs  output  CNT_W  partial instructions discarded.
- opcode_drops  output  CNT_W  words dropped by the opcode check (0 when the feature is compiled out).

Behaviour:
- Beat acceptance: a beat is accepted when in_valid && in_ready is true at a rising clock edge.
- Beat order:
  - beat0 → a
  - beat1 → b
  - beat2 → opcode = in_data[31:24], address = in_data[23:0]
- Assembly state machine, states ST_A, ST_B, ST_OP; reset state ST_A:
  - ST_A: accepted beat with in_first=1 → capture a, go to ST_B. Accepted beat with in_first=0 → discard the beat, increment resync_errs, stay in ST_A.
  - ST_B: accepted beat with in_first=0 → capture b, go to ST_OP. Accepted beat with in_first=1 → increment resync_errs, capture it as a new a, stay in ST_B.
  - ST_OP: accepted beat with in_first=0 → push the assembled word to the FIFO, go to ST_A. Accepted beat with in_first=1 → increment resync_errs, capture it as a, go to ST_B.
- in_ready:
  - Always 1 in ST_A and ST_B.
  - In ST_OP, in_ready = !full.
  - No combinational path from iw_ready to in_ready.
- Latency: the beat2 accept edge writes the FIFO. iw_valid is asserted from the next cycle, i.e. one cycle after the accept edge when the FIFO was empty.
- FIFO:
  - iw is driven from the head entry, and iw is stable while iw_valid && !iw_ready.
  - A pop happens on iw_valid && iw_ready.
  - Simultaneous push and pop: fifo_count unchanged and ordering preserved. Push with pop is legal at DEPTH-1; push while full cannot occur.
  - Pointers wrap modulo DEPTH.
- Counters: resync_errs and opcode_drops saturate at all-ones and never wrap.
- Reset values:
  - iw_valid=0, in_ready=1, iw=0, fifo_count=0, resync_errs=0, opcode_drops=0, state ST_A.
  - FIFO contents are don't-care but iw reads 0.
- Reset mid-operation discards any partial instruction and all queued words. No word accepted before reset appears after it.

Optional Feature:
- Macro: IW_OPCODE_CHECK_EN.
- Defined:
  - Package constant OPCODE_MAX = 8'h3F.
  - On completing beat2, an opcode > OPCODE_MAX is not pushed. opcode_drops increments and the state returns to ST_A.
  - in_ready in ST_OP stays !full, even for words that will be dropped.
- Undefined:
  - All opcodes are pushed.
  - opcode_drops is tied to 0.

Decomposition:
- Package iw_pkg holds:
  - instruction_word_t (packed: int a, b; byte opcode; bit [23:0] address)
  - enum asm_state_t {ST_A, ST_B, ST_OP}
  - OPCODE_MAX
  - IW_W = $bits(instruction_word_t)
- Sub-module iw_fifo (DEPTH, element type instruction_word_t) provides synchronous push/pop, count, full and empty.
- The top level holds the state machine, the counters and the opcode check.

Test Plan:
- Basic assembly: beats 32'h11111111(first), 32'h22222222, 32'h05ABCDEF with iw_ready=1 → one cycle after the beat2 accept edge, iw_valid=1 with a=32'h11111111, b=32'h22222222, opcode=8'h05, address=24'hABCDEF; pop on the next edge.
- Backpressure: iw_ready=0, send 3 instructions with DEPTH=2 → fifo_count reaches 2 and in_ready=0 in ST_OP for the third. Raise iw_ready → words emerge in order and the third is accepted after the first pop.
- Resync: first, beat, then first=1 with 32'hAAAA0000 followed by two beats → resync_errs=1, and the output word has a=32'hAAAA0000.
- Stray beat: beat with in_first=0 in ST_A → discarded, resync_errs=1, no output word.
- Reset mid-operation: reset asserted after beat1 with one word queued → next cycle iw_valid=0, fifo_count=0. A fresh instruction then assembles correctly.
- With IW_OPCODE_CHECK_EN: opcode 8'h40 → no iw_valid, opcode_drops=1. Opcode 8'h3F → delivered. Saturation: 260 stray beats with CNT_W=8 → resync_errs=8'hFF.
